// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package mdu_pkg;

    // Operation encoding as presented by the EX stage.
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_t;

    // Control states of the unit.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mdu_state_t;

    // Signed variants have a cleared low opcode bit.
    function automatic logic is_signed(input mdu_op_t op);
        return ~op[0];
    endfunction

    // Divide variants have the high opcode bit set.
    function automatic logic is_div(input mdu_op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_iterative_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface mdu_iterative_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    mdu_op_t          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic             hilo_we;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Pipeline side: issues requests, consumes results.
    modport master (
        output start, op, a, b, cancel,
        input  busy, done, hilo_we, hi, lo
    );

    // Unit side.
    modport slave (
        input  start, op, a, b, cancel,
        output busy, done, hilo_we, hi, lo
    );
endinterface

// File: rtl/mdu_step.sv
// One iteration of the unsigned datapath: a shift-add multiply step or a
// restoring shift-subtract divide step on the {acc, low} register pair.
// Multiply: low holds the multiplier, opnd the multiplicand; after WIDTH
//           steps {acc, low} is the product.
// Divide:   low holds the dividend (quotient bits shift in from the right),
//           opnd the divisor; after WIDTH steps acc is the remainder.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_low,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_low
);
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    // Select the multiply or divide step result.
    always_comb begin
        w_sum   = {1'b0, i_acc} + (i_low[0] ? {1'b0, i_opnd} : '0);
        w_shift = {i_acc, i_low[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, i_opnd});
        w_diff  = w_shift - {1'b0, i_opnd};
        if (i_div) begin
            // Partial remainder is always below the divisor, so it fits WIDTH bits.
            o_acc = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            o_low = {i_low[WIDTH-2:0], w_ge};
        end else begin
            o_acc = w_sum[WIDTH:1];
            o_low = {w_sum[0], i_low[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit: magnitudes are processed over WIDTH
// cycles, then signs and special cases are applied in a single FIX cycle.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mdu_iterative_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_t       r_state;
    mdu_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_low;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_div;
    logic             r_neg_lo;
    logic             r_neg_hi;
    logic             r_bzero;
    logic             r_ovf;

    logic             w_accept;
    logic             w_cnt_last;
    logic             w_sgn;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [WIDTH-1:0] w_step_acc;
    logic [WIDTH-1:0] w_step_low;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;
    logic [2*WIDTH-1:0] w_prod;

    assign w_accept   = bus.start && !bus.cancel;
    assign w_cnt_last = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_sgn      = is_signed(bus.op);
    assign w_a_abs    = (w_sgn && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    assign w_b_abs    = (w_sgn && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .i_div  (r_div),
        .i_acc  (r_acc),
        .i_low  (r_low),
        .i_opnd (r_opnd),
        .o_acc  (w_step_acc),
        .o_low  (w_step_low)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic; cancel overrides everything, including a new start.
    always_comb begin
        w_state_next = r_state;
        if (bus.cancel) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: if (w_accept) w_state_next = RUN;
                RUN:  if (w_cnt_last) w_state_next = FIX;
                FIX:  w_state_next = DONE;
                DONE: w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Sign correction and special cases applied to the unsigned result.
    always_comb begin
        w_prod   = {r_acc, r_low};
        w_fix_hi = '0;
        w_fix_lo = '0;
        if (!r_div) begin
            if (r_neg_lo) w_prod = ~w_prod + 1'b1;
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end else if (r_ovf) begin
            w_fix_hi = '0;
            w_fix_lo = MOST_NEG;
        end else begin
            // With a zero divisor the remainder is |a|, so restoring the
            // dividend sign hands back the original a.
            w_fix_hi = r_neg_hi ? (~r_acc + 1'b1) : r_acc;
            if (r_bzero)       w_fix_lo = '1;
            else if (r_neg_lo) w_fix_lo = ~r_low + 1'b1;
            else               w_fix_lo = r_low;
        end
    end

    // Operand capture, iteration registers and the result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_low    <= '0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_div    <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_bzero  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_div    <= is_div(bus.op);
                        r_low    <= w_a_abs;
                        r_opnd   <= w_b_abs;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_neg_lo <= w_sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_neg_hi <= w_sgn && is_div(bus.op) && bus.a[WIDTH-1];
                        r_bzero  <= is_div(bus.op) && (bus.b == '0);
                        r_ovf    <= (bus.op == OP_DIV) && (bus.a == MOST_NEG) && (bus.b == '1);
                    end
                end
                RUN: begin
                    if (!bus.cancel) begin
                        r_acc <= w_step_acc;
                        r_low <= w_step_low;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                FIX: begin
                    if (!bus.cancel) begin
                        r_hi <= w_fix_hi;
                        r_lo <= w_fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = (r_state == DONE);
    assign bus.hilo_we = (r_state == DONE);
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: vector table plus cancel/reset/interference sequences.
module tb_mdu_iterative;
    import mdu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mdu_iterative_if #(.WIDTH(32)) bus ();

    mdu_iterative #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        mdu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one op and follow it until the unit is idle again (bounded).
    task automatic run_op(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input bit spam, output int lat, output int bcyc,
                          output int ndone, output int we_bad);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat    = -1;
        bcyc   = bus.busy ? 1 : 0;
        ndone  = 0;
        we_bad = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy) bcyc++;
            if (bus.hilo_we !== bus.done) we_bad++;
            if (bus.done) begin
                ndone++;
                if (lat < 0) lat = i;
            end
            if (spam) begin
                bus.start = (i >= 2 && i <= 20);
                bus.op    = OP_MULTU;
                bus.a     = 32'hFFFF_FFFF;
                bus.b     = 32'hFFFF_FFFF;
            end
            if (!bus.busy) break;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int lat, bcyc, ndone, we_bad, cnt;
        checks = 0;
        errors = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = OP_MULT;
        bus.a      = '0;
        bus.b      = '0;

        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4]  = '{OP_DIV,   32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD};
        vecs[5]  = '{OP_DIVU,  32'h7,         32'h0,         32'h7,         32'hFFFF_FFFF};
        vecs[6]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
        vecs[7]  = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1,         32'h0};
        vecs[8]  = '{OP_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0,         32'hF};
        vecs[9]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
        vecs[10] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[11] = '{OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h3};
        vecs[12] = '{OP_MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
        vecs[13] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h1,         32'h0,         32'hFFFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",    {31'b0, bus.busy},    32'd0);
        chk("reset_done",    {31'b0, bus.done},    32'd0);
        chk("reset_hilo_we", {31'b0, bus.hilo_we}, 32'd0);
        chk("reset_hi",      bus.hi,               32'd0);
        chk("reset_lo",      bus.lo,               32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, bcyc, ndone, we_bad);
            $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d busy=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, bus.hi, bus.lo, lat, bcyc);
            chk($sformatf("vec%0d_hi", i), bus.hi, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), bus.lo, vecs[i].lo);
            chk($sformatf("vec%0d_latency", i), lat, 32'd33);
            chk($sformatf("vec%0d_done_pulses", i), ndone, 32'd1);
            chk($sformatf("vec%0d_hilo_we", i), we_bad, 32'd0);
            if (i == 0) chk("vec0_busy_cycles", bcyc, 32'd34);
        end

        // start pulses while running must be ignored
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b1, lat, bcyc, ndone, we_bad);
        $display("interference divu 100/7 -> hi=%h lo=%h lat=%0d", bus.hi, bus.lo, lat);
        chk("spam_hi", bus.hi, 32'd2);
        chk("spam_lo", bus.lo, 32'd14);
        chk("spam_latency", lat, 32'd33);
        chk("spam_done_pulses", ndone, 32'd1);

        // cancel 10 cycles into RUN
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd5; bus.b = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.cancel = 1'b1;
        @(posedge clk);
        #1;
        bus.cancel = 1'b0;
        chk("cancel_busy", {31'b0, bus.busy}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.hilo_we) cnt++;
        end
        $display("cancel mid-run -> busy=%0d done_seen=%0d hi=%h lo=%h", bus.busy, cnt, bus.hi, bus.lo);
        chk("cancel_no_done", cnt, 32'd0);
        chk("cancel_hi_kept", bus.hi, 32'd2);
        chk("cancel_lo_kept", bus.lo, 32'd14);

        // start together with cancel in IDLE
        @(negedge clk);
        bus.start = 1'b1; bus.cancel = 1'b1; bus.op = OP_MULTU; bus.a = 32'd3; bus.b = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.cancel = 1'b0;
        chk("start_cancel_busy", {31'b0, bus.busy}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) cnt++;
        end
        $display("start+cancel idle -> activity=%0d hi=%h lo=%h", cnt, bus.hi, bus.lo);
        chk("start_cancel_idle", cnt, 32'd0);
        chk("start_cancel_hi", bus.hi, 32'd2);

        // asynchronous reset mid-RUN
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'h0001_0000; bus.b = 32'h0001_0000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        $display("async reset mid-run -> busy=%0d done=%0d hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
        chk("arst_busy", {31'b0, bus.busy}, 32'd0);
        chk("arst_done", {31'b0, bus.done}, 32'd0);
        chk("arst_hi",   bus.hi,            32'd0);
        chk("arst_lo",   bus.lo,            32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, lat, bcyc, ndone, we_bad);
        $display("after reset div -7/-2 -> hi=%h lo=%h lat=%0d", bus.hi, bus.lo, lat);
        chk("post_rst_hi", bus.hi, 32'hFFFF_FFFF);
        chk("post_rst_lo", bus.lo, 32'h3);
        chk("post_rst_latency", lat, 32'd33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
